// File: rtl/odo_round_engine_if.sv
// Job, result and round-function buses of the Odo round engine.
// The engine uses the slave view; the dispatcher, finaliser and round-function pipeline use the master view.
interface odo_round_engine_if #(
  parameter int STATE_W = 640,
  parameter int KEY_W   = 10,
  parameter int RCNT_W  = 7,
  parameter int ID_W    = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_data;
  logic [KEY_W-1:0]   in_key;
  logic [RCNT_W-1:0]  in_rounds;
  logic [ID_W-1:0]    in_id;

  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_data;
  logic [ID_W-1:0]    out_id;

  logic               rf_en;
  logic [STATE_W-1:0] rf_in;
  logic [KEY_W-1:0]   rf_key;
  logic [STATE_W-1:0] rf_out;

  modport slave (
    input  in_valid, in_data, in_key, in_rounds, in_id,
    output in_ready,
    output out_valid, out_data, out_id,
    input  out_ready,
    output rf_en, rf_in, rf_key,
    input  rf_out
  );

  modport master (
    output in_valid, in_data, in_key, in_rounds, in_id,
    input  in_ready,
    input  out_valid, out_data, out_id,
    output out_ready,
    input  rf_en, rf_in, rf_key,
    output rf_out
  );
endinterface

// File: rtl/odo_round_engine.sv
// Multi-context round sequencer: RF_LAT jobs recirculate through an external round-function pipeline.
// Result valid T*RF_LAT+1 cycles after accept; a held result blocking a finished job stalls the whole ring.
module odo_round_engine #(
  parameter int STATE_W    = 640,
  parameter int KEY_W      = 10,
  parameter int MAX_ROUNDS = 84,
  parameter int RF_LAT     = 2,
  parameter int ID_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  odo_round_engine_if.slave bus,
  output logic              busy
);
  localparam int RCNT_W = $clog2(MAX_ROUNDS + 1);

  typedef struct packed {
    logic              vld;
    logic [ID_W-1:0]   id;
    logic [KEY_W-1:0]  key;
    logic [RCNT_W-1:0] r;
    logic [RCNT_W-1:0] t;
  } tag_t;

  // ring[0] holds the tag that entered last cycle; ring[RF_LAT-1] matches rf_out
  tag_t ring [RF_LAT];
  tag_t head;
  tag_t ent;

  logic              head_done;
  logic              advance;
  logic              slot_free;
  logic [RCNT_W-1:0] in_t;

  assign head      = ring[RF_LAT-1];
  assign head_done = head.vld && (head.r == head.t - RCNT_W'(1));
  assign advance   = rst || !(head_done && bus.out_valid && !bus.out_ready);
  assign slot_free = !head.vld || head_done;
  assign in_t      = (bus.in_rounds == '0) ? RCNT_W'(MAX_ROUNDS) : bus.in_rounds;

  assign bus.rf_en    = advance;
  assign bus.in_ready = advance && !rst && slot_free;

  always_comb begin
    ent        = '0;
    bus.rf_in  = '0;
    bus.rf_key = '0;
    if (!rst) begin
      if (head.vld && !head_done) begin
        ent        = head;
        ent.r      = head.r + RCNT_W'(1);
        bus.rf_in  = bus.rf_out;
        bus.rf_key = head.key + KEY_W'(ent.r);
      end else if (bus.in_valid) begin
        ent.vld    = 1'b1;
        ent.id     = bus.in_id;
        ent.key    = bus.in_key;
        ent.r      = '0;
        ent.t      = in_t;
        bus.rf_in  = bus.in_data;
        bus.rf_key = bus.in_key;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RF_LAT; i++) ring[i] <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_id    <= '0;
    end else if (advance) begin
      ring[0] <= ent;
      for (int i = 1; i < RF_LAT; i++) ring[i] <= ring[i-1];
      if (head_done) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= bus.rf_out;
        bus.out_id    <= head.id;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    busy = bus.out_valid;
    for (int i = 0; i < RF_LAT; i++) busy = busy | ring[i].vld;
  end
endmodule

// File: tb/tb_odo_round_engine.sv
// Directed bench for odo_round_engine with a 2-stage rf_out = rf_in + rf_key model.
// Expected results are queued at stimulus time and popped by an independent output monitor.
module tb_odo_round_engine;
  localparam int STATE_W    = 32;
  localparam int KEY_W      = 10;
  localparam int MAX_ROUNDS = 4;
  localparam int RF_LAT     = 2;
  localparam int ID_W       = 4;
  localparam int RCNT_W     = $clog2(MAX_ROUNDS + 1);

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [STATE_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t expq[$];
  logic [STATE_W-1:0] p0 = '0;
  logic [STATE_W-1:0] p1 = '0;

  odo_round_engine_if #(.STATE_W(STATE_W), .KEY_W(KEY_W), .RCNT_W(RCNT_W), .ID_W(ID_W)) bus ();

  odo_round_engine #(
    .STATE_W(STATE_W), .KEY_W(KEY_W), .MAX_ROUNDS(MAX_ROUNDS), .RF_LAT(RF_LAT), .ID_W(ID_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External round function: two enabled stages
  always @(posedge clk) begin
    if (bus.rf_en) begin
      p0 <= bus.rf_in + STATE_W'(bus.rf_key);
      p1 <= p0;
    end
  end
  assign bus.rf_out = p1;

  function automatic exp_t mk(input logic [ID_W-1:0] id, input logic [STATE_W-1:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result: got id=%0d data=0x%0h, required no result", bus.out_id, bus.out_data);
      end else begin
        exp_t e;
        e = expq.pop_front();
        if (bus.out_id !== e.id || bus.out_data !== e.data) begin
          fails++;
          $display("FAIL result: got id=%0d data=0x%0h, required id=%0d data=0x%0h",
                   bus.out_id, bus.out_data, e.id, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Hold a job on the input until accepted; leaves in_valid high for back-to-back offers
  task automatic offer(input logic [ID_W-1:0] id, input logic [STATE_W-1:0] d,
                       input logic [KEY_W-1:0] k, input logic [RCNT_W-1:0] n,
                       output int acc, output int waits, output logic [KEY_W-1:0] key_seen);
    bus.in_valid  = 1'b1;
    bus.in_id     = id;
    bus.in_data   = d;
    bus.in_key    = k;
    bus.in_rounds = n;
    acc = -1;
    waits = 0;
    key_seen = '0;
    for (int i = 0; i < 50 && acc < 0; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = cyc;
        key_seen = bus.rf_key;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    if (acc < 0) timeout("offer");
  endtask

  task automatic at_cycle(input int n);
    @(negedge clk);
    for (int i = 0; i < 1000 && cyc < n; i++) @(negedge clk);
  endtask

  task automatic wait_out(output int c);
    c = -1;
    for (int i = 0; i < 100 && c < 0; i++) begin
      @(negedge clk);
      if (bus.out_valid) c = cyc;
    end
    if (c < 0) timeout("wait_out_valid");
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && expq.size() > 0; i++) @(negedge clk);
    if (expq.size() > 0) timeout("drain");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by itself");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, w, a, b, c;
    logic [KEY_W-1:0] k;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_key    = '0;
    bus.in_rounds = '0;
    bus.in_id     = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_out_id", bus.out_id, 0);
    check("reset_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // 1: single job, keys 5,6,7
    bus.out_ready = 1'b1;
    expq.push_back(mk(4'd1, 32'h112));
    offer(4'd1, 32'h100, 10'd5, 3'd3, t, w, k);
    bus.in_valid = 1'b0;
    check("t1_key_r0", k, 5);
    at_cycle(t + 2);
    check("t1_key_r1", bus.rf_key, 6);
    check("t1_rf_in_r1", bus.rf_in, 32'h105);
    at_cycle(t + 4);
    check("t1_key_r2", bus.rf_key, 7);
    wait_out(c);
    check("t1_latency", c - t, 7);
    at_cycle(c + 1);
    check("t1_busy_after", busy, 0);
    check("t1_out_valid_after", bus.out_valid, 0);
    @(posedge clk);
    #1;

    // 2: A, B back-to-back, C held until A's slot frees
    expq.push_back(mk(4'd1, 32'h13));
    expq.push_back(mk(4'd2, 32'h41));
    expq.push_back(mk(4'd5, 32'h33));
    offer(4'd1, 32'h10, 10'd1, 3'd2, a, w, k);
    offer(4'd2, 32'h20, 10'h10, 3'd2, b, w, k);
    check("t2_b_accept_cycle", b, a + 1);
    offer(4'd5, 32'h30, 10'd3, 3'd1, c, w, k);
    bus.in_valid = 1'b0;
    check("t2_c_accept_cycle", c, a + 4);
    check("t2_c_wait_cycles", w, 2);
    drain();

    // 3: longer job first, short job overtakes
    expq.push_back(mk(4'd4, 32'h2007));
    expq.push_back(mk(4'd3, 32'h1086));
    offer(4'd3, 32'h1000, 10'h20, 3'd4, a, w, k);
    offer(4'd4, 32'h2000, 10'd7, 3'd1, b, w, k);
    bus.in_valid = 1'b0;
    check("t3_b_accept_cycle", b, a + 1);
    drain();

    // 4: rounds=0 means MAX_ROUNDS, key wraps
    expq.push_back(mk(4'd6, 32'h7FE));
    offer(4'd6, 32'h0, 10'h3FE, 3'd0, t, w, k);
    bus.in_valid = 1'b0;
    check("t4_key_r0", k, 10'h3FE);
    at_cycle(t + 2);
    check("t4_key_r1", bus.rf_key, 10'h3FF);
    at_cycle(t + 4);
    check("t4_key_r2_wrap", bus.rf_key, 10'h000);
    at_cycle(t + 6);
    check("t4_key_r3", bus.rf_key, 10'h001);
    wait_out(c);
    check("t4_latency", c - t, 9);
    drain();

    // 5: backpressure stalls the ring while a finished job waits
    bus.out_ready = 1'b0;
    expq.push_back(mk(4'd7, 32'h51));
    expq.push_back(mk(4'd8, 32'h65));
    offer(4'd7, 32'h50, 10'd1, 3'd1, t, w, k);
    offer(4'd8, 32'h60, 10'd2, 3'd2, b, w, k);
    bus.in_valid = 1'b0;
    at_cycle(t + 5);
    check("t5_stall_rf_en", bus.rf_en, 0);
    check("t5_stall_in_ready", bus.in_ready, 0);
    check("t5_held_valid", bus.out_valid, 1);
    check("t5_held_data", bus.out_data, 32'h51);
    check("t5_held_id", bus.out_id, 7);
    at_cycle(t + 7);
    check("t5_stall_rf_en_later", bus.rf_en, 0);
    check("t5_held_data_later", bus.out_data, 32'h51);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("t5_second_valid", bus.out_valid, 1);
    check("t5_second_data", bus.out_data, 32'h65);
    check("t5_second_id", bus.out_id, 8);
    check("t5_resume_rf_en", bus.rf_en, 1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    drain();

    // 6: reset mid-job with a held result and two jobs in flight
    bus.out_ready = 1'b0;
    offer(4'd9, 32'h1, 10'd1, 3'd1, t, w, k);
    offer(4'd10, 32'h100, 10'd0, 3'd4, a, w, k);
    offer(4'd11, 32'h200, 10'd0, 3'd4, b, w, k);
    bus.in_valid = 1'b0;
    check("t6_third_accept_cycle", b, t + 2);
    wait_out(c);
    check("t6_busy_before_rst", busy, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t6_rst_rf_en", bus.rf_en, 1);
    check("t6_rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_after_rst_out_valid", bus.out_valid, 0);
    check("t6_after_rst_busy", busy, 0);
    check("t6_after_rst_out_data", bus.out_data, 0);
    check("t6_after_rst_out_id", bus.out_id, 0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    expq.push_back(mk(4'd12, 32'h49));
    offer(4'd12, 32'h40, 10'd4, 3'd2, t, w, k);
    bus.in_valid = 1'b0;
    drain();
    repeat (12) @(negedge clk);
    check("t6_final_busy", busy, 0);
    check("t6_final_queue", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
